// File: rtl/aes_decryption_pkg.sv
// Shared AES-128 decrypt definitions: slot tag, round count and the inverse S-box.
package aes_pkg;
    localparam int NUM_ROUNDS = 10;

    typedef struct packed {
        logic       valid;
        logic [3:0] rounds;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{valid: 1'b0, rounds: 4'd0};
    localparam tag_t TAG_LOAD  = '{valid: 1'b1, rounds: 4'd0};
    localparam tag_t TAG_DONE  = '{valid: 1'b1, rounds: 4'(NUM_ROUNDS)};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        int unsigned idx;
        idx = 2047 - 8 * int'(b);
        return INV_SBOX[idx -: 8];
    endfunction
endpackage

// File: rtl/aes_decryption_inv_mix_columns.sv
// InvMixColumns over a 128-bit state: each column multiplied by {0e,0b,0d,09} in GF(2^8).
module inv_mix_columns (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_in[127 - 32*c      -: 8];
        assign a1 = data_in[127 - 32*c - 8  -: 8];
        assign a2 = data_in[127 - 32*c - 16 -: 8];
        assign a3 = data_in[127 - 32*c - 24 -: 8];
        assign data_out[127 - 32*c      -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
        assign data_out[127 - 32*c - 8  -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
        assign data_out[127 - 32*c - 16 -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
        assign data_out[127 - 32*c - 24 -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
endmodule

// File: rtl/aes_decryption.sv
// AES-128 inverse cipher: three interleaved slots recirculate through a 3-stage round pipeline.
module aes_decryption
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         read_fifo,
    input  logic [127:0] fifo_in,
    input  logic         is_full,
    input  logic [127:0] round_key_input,
    input  logic [127:0] round_key_10,
    output logic         load_ready,
    output logic [3:0]   round_key_addr,
    output logic [127:0] data_output,
    output logic         data_valid,
    output logic         data_done
);
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c - w + 4) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int lane = 0; lane < 4; lane++) begin
            for (int b = 0; b < 4; b++) begin
                r[127 - 32*lane - 8*b -: 8] = inv_sbox(s[127 - 32*lane - 8*b -: 8]);
            end
        end
        return r;
    endfunction

    tag_t         tag_sel, tag_p0, tag_p1, tag_p2;
    logic [127:0] blk_sel, blk_p0, blk_p1, blk_p2;
    logic [127:0] imc_p1;
    logic         c_busy;

    assign c_busy     = tag_p2.valid && (tag_p2 != TAG_DONE);
    assign load_ready = !is_full && (!tag_p2.valid || (tag_p2 == TAG_DONE));

    // A finished slot leaves this cycle, so it is treated as free for a new load.
    always_comb begin
        blk_sel = '0;
        tag_sel = TAG_EMPTY;
        if (c_busy) begin
            blk_sel = blk_p2;
            tag_sel = tag_p2;
        end else if (read_fifo && load_ready) begin
            blk_sel = fifo_in ^ round_key_10;
            tag_sel = TAG_LOAD;
        end
    end

    assign round_key_addr = 4'd9 - tag_p0.rounds;

    inv_mix_columns u_imc (
        .data_in  (blk_p1),
        .data_out (imc_p1)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_p0 <= '0;
            tag_p0 <= TAG_EMPTY;
            blk_p1 <= '0;
            tag_p1 <= TAG_EMPTY;
            blk_p2 <= '0;
            tag_p2 <= TAG_EMPTY;
        end else if (!is_full) begin
            // stage A: InvShiftRows then InvSubBytes
            blk_p0 <= inv_sub_bytes(inv_shift_rows(blk_sel));
            tag_p0 <= tag_sel;
            // stage B: round key addition
            blk_p1 <= blk_p0 ^ round_key_input;
            tag_p1 <= tag_p0;
            // stage C: InvMixColumns except in the last round, round count advances
            blk_p2 <= (tag_p1.rounds == 4'(NUM_ROUNDS - 1)) ? blk_p1 : imc_p1;
            tag_p2 <= tag_p1.valid ? tag_t'({1'b1, tag_p1.rounds + 4'd1}) : tag_p1;
        end
    end

    assign data_output = blk_p2;
    assign data_valid  = tag_p2.valid;
    assign data_done   = (tag_p2 == TAG_DONE);
endmodule

// File: tb/tb_aes_decryption.sv
// Scoreboard bench for aes_decryption against a forward AES-128 reference model.
module tb_aes_decryption;
    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         read_fifo = 1'b0;
    logic [127:0] fifo_in = '0;
    logic         is_full = 1'b0;
    logic [127:0] round_key_input;
    logic [127:0] round_key_10;
    logic         load_ready;
    logic [3:0]   round_key_addr;
    logic [127:0] data_output;
    logic         data_valid;
    logic         data_done;

    aes_decryption dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .read_fifo       (read_fifo),
        .fifo_in         (fifo_in),
        .is_full         (is_full),
        .round_key_input (round_key_input),
        .round_key_10    (round_key_10),
        .load_ready      (load_ready),
        .round_key_addr  (round_key_addr),
        .data_output     (data_output),
        .data_valid      (data_valid),
        .data_done       (data_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // key store: round keys 0..10, remaining addresses read as zero
    logic [127:0] rk [16];
    initial for (int i = 0; i < 16; i++) rk[i] = '0;
    assign round_key_input = rk[round_key_addr];
    assign round_key_10    = rk[10];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] pt;
        int           exp_cyc;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;
    bit  rand_full = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        int unsigned idx;
        idx = 2047 - 8 * int'(x);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher: bench derives ciphertext from plaintext, DUT must invert it.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // monitor: a DONE word is consumed when is_full is low
    always @(negedge clk) begin
        if (data_done && !is_full) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got %h with nothing outstanding (cycle %0d)", data_output, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("plaintext", data_output, mon_e.pt);
                if (mon_e.exp_cyc >= 0) chk("done_cycle", 128'(cyc), 128'(mon_e.exp_cyc));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_full) is_full = ($urandom_range(0, 3) == 0);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input logic [127:0] ct, input logic [127:0] pt, input int lat,
                         input int max_wait, output int acc);
        read_fifo = 1'b1;
        fifo_in   = ct;
        acc       = -1;
        for (int i = 0; i < max_wait && acc < 0; i++) begin
            @(negedge clk);
            if (load_ready) begin
                acc = cyc;
                sbq.push_back('{pt, (lat >= 0) ? cyc + lat : -1});
            end
            @(posedge clk);
            #1;
        end
        read_fifo = 1'b0;
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL offer_timeout: got no load_ready in %0d cycles, expected acceptance", max_wait);
        end
    endtask

    task automatic goto_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d blocks outstanding, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, k0, acc;
        logic [127:0] pt, ct;

        expand(128'h000102030405060708090a0b0c0d0e0f);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_output", data_output, '0);
        chk("rst_data_valid", 128'(data_valid), '0);
        chk("rst_data_done", 128'(data_done), '0);
        chk("rst_key_addr", 128'(round_key_addr), 128'(9));
        chk("rst_load_ready", 128'(load_ready), 128'(1));
        n_rst = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_valid_done", 128'({data_valid, data_done}), '0);
        end
        @(posedge clk);
        #1;

        // FIPS-197 C.1
        chk("fips_round_key_10", round_key_10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        offer(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 30, 5, k);
        for (int r = 0; r < 10; r++) begin
            goto_neg(k + 1 + 3*r);
            chk("key_addr", 128'(round_key_addr), 128'(9 - r));
        end
        drain(100);

        // three back-to-back loads, fourth waits for the first DONE slot
        offer(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 30, 5, k0);
        pt = rnd128(); offer(aes_enc(pt), pt, 30, 5, acc);
        chk("b2b_second_accept", 128'(acc), 128'(k0 + 1));
        pt = rnd128(); offer(aes_enc(pt), pt, 30, 5, acc);
        chk("b2b_third_accept", 128'(acc), 128'(k0 + 2));
        pt = rnd128(); offer(aes_enc(pt), pt, 30, 40, acc);
        chk("fourth_accept_cycle", 128'(acc), 128'(k0 + 30));
        drain(100);

        // 7-cycle stall mid-decryption
        pt = rnd128();
        offer(aes_enc(pt), pt, 37, 5, k);
        goto_neg(k + 10);
        @(posedge clk);
        #1;
        is_full = 1'b1;
        @(negedge clk);
        chk("stall_load_ready", 128'(load_ready), '0);
        repeat (7) @(posedge clk);
        #1;
        is_full = 1'b0;
        drain(100);

        // is_full overlapping the DONE cycle
        pt = rnd128();
        offer(aes_enc(pt), pt, 35, 5, k);
        goto_neg(k + 29);
        @(posedge clk);
        #1;
        is_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_done", 128'(data_done), 128'(1));
            chk("held_load_ready", 128'(load_ready), '0);
        end
        @(posedge clk);
        #1;
        is_full = 1'b0;
        drain(100);

        // reset mid-decryption
        pt = rnd128();
        offer(aes_enc(pt), pt, 30, 5, k);
        goto_neg(k + 15);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_data_output", data_output, '0);
        chk("midrst_valid_done", 128'({data_valid, data_done}), '0);
        chk("midrst_key_addr", 128'(round_key_addr), 128'(9));
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst_valid_done", 128'({data_valid, data_done}), '0);
        end
        @(posedge clk);
        #1;

        // randomized key, blocks, gaps and backpressure
        expand(rnd128());
        rand_full = 1'b1;
        for (int b = 0; b < 16; b++) begin
            pt = rnd128();
            offer(aes_enc(pt), pt, -1, 500, acc);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_full = 1'b0;
        @(posedge clk);
        #2;
        is_full = 1'b0;
        drain(2000);

        chk("scoreboard_empty", 128'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
